tohost_monitor: RTL and testbench

TOHOST_MONITOR -- requirements
Module: tohost_monitor

---
 rtl/tohost_pkg.sv | 18 +
 rtl/sync_fifo.sv | 48 ++++
 rtl/tohost_monitor.sv | 121 ++++++++++++
 tb/tb_tohost_monitor.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/tohost_pkg.sv
// Shared state encoding and parameter defaults for the tohost/console monitor.
package tohost_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam logic [31:0] DEF_ADDR_TOHOST  = 32'h1000_1000;
  localparam logic [31:0] DEF_ADDR_CONSOLE = 32'h1000_0000;
  localparam logic [7:0]  DEF_PASS_CODE    = 8'h03;
  localparam int          DEF_TIMEOUT      = 20000;
  localparam int          DEF_FIFO_DEPTH   = 16;
  localparam int          DEF_CNT_W        = 32;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/tohost_monitor.sv
// Simulation-exit monitor: decodes tohost/console bus writes, tracks run state,
// cycle/instret counters and a console byte stream.
module tohost_monitor
  import tohost_pkg::*;
#(
  parameter logic [31:0] ADDR_TOHOST  = DEF_ADDR_TOHOST,
  parameter logic [31:0] ADDR_CONSOLE = DEF_ADDR_CONSOLE,
  parameter logic [7:0]  PASS_CODE    = DEF_PASS_CODE,
  parameter int          TIMEOUT      = DEF_TIMEOUT,
  parameter int          FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int          CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic             mem_write,
  input  logic [3:0]       mem_wmask,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic             retired,
  output logic             con_valid,
  output logic [7:0]       con_data,
  input  logic             con_ready,
  output logic [1:0]       state,
  output logic             done,
  output logic             pass,
  output logic [31:0]      exit_code,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] instret,
  output logic             con_overflow
);

  localparam bit              TMO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_e           r_state;
  logic [31:0]      r_exit_code;
  logic [CNT_W-1:0] r_cycles;
  logic [CNT_W-1:0] r_instret;
  logic             r_overflow;

  logic w_wr;
  logic w_run;
  logic w_tohost_wr;
  logic w_con_req;
  logic w_tmo;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic [7:0] w_rdata;
  logic w_unused;

  assign w_unused = &{1'b0, mem_wmask[3:1]};

  assign w_wr        = mem_valid & mem_write & mem_wmask[0];
  assign w_run       = (r_state == ST_RUN);
  assign w_tohost_wr = w_run & w_wr & (mem_addr == ADDR_TOHOST);
  // Tohost decode wins when both addresses alias.
  assign w_con_req   = w_run & w_wr & (mem_addr == ADDR_CONSOLE) &
                       (mem_addr != ADDR_TOHOST);
  assign w_tmo       = TMO_EN & w_run & ~w_tohost_wr & (r_cycles == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_exit_code <= '0;
    end else if (w_tohost_wr) begin
      r_state     <= (mem_wdata[7:0] == PASS_CODE) ? ST_PASS : ST_FAIL;
      r_exit_code <= mem_wdata;
    end else if (w_tmo) begin
      r_state     <= ST_TIMEOUT;
    end
  end

  // The timeout edge itself does not count, leaving cycles at TIMEOUT-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycles  <= '0;
      r_instret <= '0;
    end else begin
      if (w_run && !w_tmo && r_cycles != '1)
        r_cycles <= r_cycles + 1'b1;
      if (w_run && retired && r_instret != '1)
        r_instret <= r_instret + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_overflow <= 1'b0;
    else if (w_con_req && w_full && !w_pop)
      r_overflow <= 1'b1;
  end

  assign w_pop = ~w_empty & con_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_con_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_con_req),
    .i_wdata (mem_wdata[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign con_valid    = ~w_empty;
  assign con_data     = w_rdata;
  assign state        = r_state;
  assign done         = (r_state != ST_RUN);
  assign pass         = (r_state == ST_PASS);
  assign exit_code    = r_exit_code;
  assign cycles       = r_cycles;
  assign instret      = r_instret;
  assign con_overflow = r_overflow;

endmodule

// File: tb/tb_tohost_monitor.sv
// Directed bench for tohost_monitor: exit decode, timeout, counters, console FIFO.
module tb_tohost_monitor;

  localparam logic [31:0] A_TH = 32'h1000_1000;
  localparam logic [31:0] A_CN = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0, mem_write = 1'b0, retired = 1'b0, con_ready = 1'b0;
  logic [3:0]  mem_wmask = 4'h0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;

  logic        con_valid, done, pass, con_overflow;
  logic [7:0]  con_data;
  logic [1:0]  state;
  logic [31:0] exit_code, cycles, instret;

  logic        d2_con_valid, d2_done, d2_pass, d2_con_overflow;
  logic [7:0]  d2_con_data;
  logic [1:0]  d2_state;
  logic [31:0] d2_exit_code, d2_cycles, d2_instret;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tohost_monitor #(.TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_write(mem_write),
    .mem_wmask(mem_wmask), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .retired(retired), .con_valid(con_valid), .con_data(con_data),
    .con_ready(con_ready), .state(state), .done(done), .pass(pass),
    .exit_code(exit_code), .cycles(cycles), .instret(instret),
    .con_overflow(con_overflow)
  );

  // Aliased addresses and timeout disabled.
  tohost_monitor #(.ADDR_CONSOLE(32'h1000_1000), .TIMEOUT(0)) dut2 (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_write(mem_write),
    .mem_wmask(mem_wmask), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .retired(retired), .con_valid(d2_con_valid), .con_data(d2_con_data),
    .con_ready(con_ready), .state(d2_state), .done(d2_done), .pass(d2_pass),
    .exit_code(d2_exit_code), .cycles(d2_cycles), .instret(d2_instret),
    .con_overflow(d2_con_overflow)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    mem_valid = 1'b1; mem_write = 1'b1; mem_addr = a; mem_wdata = d; mem_wmask = m;
    @(negedge clk);
    mem_valid = 1'b0; mem_write = 1'b0; mem_wmask = 4'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // reset values
    do_reset();
    chk("rst_state", state, 0);
    chk("rst_exit", exit_code, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_instret", instret, 0);
    chk("rst_conv", con_valid, 0);
    chk("rst_cond", con_data, 0);
    chk("rst_ovf", con_overflow, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);

    // pass at cycle 50, masked write ignored, counters freeze
    retired = 1'b1;
    idle(10);
    retired = 1'b0;
    chk("t1_instret10", instret, 10);
    wr(A_TH, 32'h3, 4'hE);
    chk("t1_mask_ignored", state, 0);
    idle(39);
    chk("t1_cyc50", cycles, 50);
    wr(A_TH, 32'h3, 4'hF);
    chk("t1_state", state, 1);
    chk("t1_cyc51", cycles, 51);
    retired = 1'b1;
    idle(5);
    retired = 1'b0;
    chk("t1_state_hold", state, 1);
    chk("t1_done", done, 1);
    chk("t1_pass", pass, 1);
    chk("t1_exit", exit_code, 3);
    chk("t1_cyc_frozen", cycles, 51);
    chk("t1_instret_frozen", instret, 10);

    // fail code, later writes ignored
    do_reset();
    wr(A_TH, 32'h55, 4'hF);
    chk("t2_state", state, 2);
    wr(A_TH, 32'h3, 4'hF);
    wr(A_CN, 32'h41, 4'hF);
    idle(1);
    chk("t2_state_hold", state, 2);
    chk("t2_exit", exit_code, 32'h55);
    chk("t2_pass", pass, 0);
    chk("t2_done", done, 1);
    chk("t2_con_ignored", con_valid, 0);

    // timeout; second instance has timeout disabled
    do_reset();
    idle(99);
    chk("t3_cyc99", cycles, 99);
    chk("t3_run99", state, 0);
    idle(1);
    chk("t3_timeout", state, 3);
    chk("t3_cyc_frozen", cycles, 99);
    idle(5);
    chk("t3_cyc_hold", cycles, 99);
    chk("t3_done", done, 1);
    chk("t3_d2_run", d2_state, 0);
    chk("t3_d2_cyc", d2_cycles, 105);

    // tohost write on the timeout cycle wins
    do_reset();
    idle(99);
    wr(A_TH, 32'h3, 4'hF);
    idle(3);
    chk("t3b_state", state, 1);
    chk("t3b_cyc", cycles, 100);

    // overflow and in-order drain
    do_reset();
    con_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr(A_CN, 32'h41 + i, 4'hF);
      if (i == 15) chk("t4_no_ovf16", con_overflow, 0);
    end
    chk("t4_ovf", con_overflow, 1);
    con_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t4_drain_v", con_valid, 1);
      chk("t4_drain_d", con_data, 8'h41 + i);
      @(negedge clk);
    end
    chk("t4_empty", con_valid, 0);
    chk("t4_empty_d", con_data, 0);
    chk("t4_ovf_sticky", con_overflow, 1);
    con_ready = 1'b0;

    // simultaneous push and pop at full
    do_reset();
    for (int i = 0; i < 16; i++) wr(A_CN, 32'h41 + i, 4'hF);
    chk("t5_full_no_ovf", con_overflow, 0);
    con_ready = 1'b1;
    wr(A_CN, 32'h5A, 4'hF);
    con_ready = 1'b0;
    chk("t5_no_ovf", con_overflow, 0);
    chk("t5_head", con_data, 8'h42);
    con_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t5_drain_d", con_data, (i == 15) ? 8'h5A : 8'h42 + i);
      @(negedge clk);
    end
    chk("t5_empty", con_valid, 0);
    con_ready = 1'b0;

    // reset mid-drain in PASS overrides same-cycle events
    do_reset();
    for (int i = 0; i < 5; i++) wr(A_CN, 32'h61 + i, 4'hF);
    wr(A_TH, 32'h3, 4'hF);
    chk("t6_pass", state, 1);
    chk("t6_queued", con_valid, 1);
    rst = 1'b1; retired = 1'b1;
    mem_valid = 1'b1; mem_write = 1'b1; mem_addr = A_CN; mem_wdata = 32'h58; mem_wmask = 4'hF;
    @(negedge clk);
    rst = 1'b0; retired = 1'b0; mem_valid = 1'b0; mem_write = 1'b0; mem_wmask = 4'h0;
    chk("t6_state", state, 0);
    chk("t6_conv", con_valid, 0);
    chk("t6_cond", con_data, 0);
    chk("t6_cycles", cycles, 0);
    chk("t6_instret", instret, 0);
    chk("t6_exit", exit_code, 0);
    chk("t6_done", done, 0);

    // aliased addresses: tohost wins, no push
    wr(A_TH, 32'h41, 4'hF);
    idle(1);
    chk("t7_d2_state", d2_state, 2);
    chk("t7_d2_exit", d2_exit_code, 32'h41);
    chk("t7_d2_conv", d2_con_valid, 0);
    chk("t7_d2_ovf", d2_con_overflow, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
